// File: rtl/usb_tx_gen.sv
// USB packet transmitter: SYNC, PID, optional payload with CRC16, bit stuffing,
// NRZI line coding and EOP generation, all on one clock domain.
module usb_tx_gen #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] tx_packet_data_size,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet,
  output logic       dPlus_out,
  output logic       dMinus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int            CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [6:0]    MAX_SIZE = 7'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PID     = 3'd2,
    DATA    = 3'd3,
    CRC     = 3'd4,
    EOP_SE0 = 3'd5,
    EOP_J   = 3'd6
  } state_t;

  // state_r/idx_r point at the next field bit to emit, not the one on the wire
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    idx_r;
  logic [2:0]    ones_r;
  logic [15:0]   crc_r;
  logic [7:0]    pid_r;
  logic [7:0]    shift_r;
  logic [6:0]    bytes_left_r;
  logic          is_data_r;
  logic          fetch_due_r;
  logic          nrzi_r;

  logic          req_valid_s;
  logic          is_data_req_s;
  logic          wrap_s;
  logic          stuff_s;
  logic          last_s;
  logic          field_bit_s;
  logic          tx_bit_s;
  logic          line_s;
  logic [7:0]    data_byte_s;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = d ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  function automatic logic [7:0] pid_of(input logic [2:0] code);
    case (code)
      3'd1:    return 8'hC3;
      3'd2:    return 8'h4B;
      3'd3:    return 8'hD2;
      3'd4:    return 8'h5A;
      3'd5:    return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

  // Request decode and selection of the next bit and its NRZI line level.
  always_comb begin
    is_data_req_s = (tx_packet == 3'd1) || (tx_packet == 3'd2);
    req_valid_s   = (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
    wrap_s        = (cnt_r == CNT_LAST);
    stuff_s       = (ones_r == 3'd6);
    // a byte popped this clock is not yet in shift_r but its bit 0 is due now
    data_byte_s   = get_tx_packet ? tx_packet_data : shift_r;
    last_s        = (state_r == CRC) ? (idx_r == 4'd15) : (idx_r == 4'd7);
    case (state_r)
      SYNC:    field_bit_s = (idx_r[2:0] == 3'd7);
      PID:     field_bit_s = pid_r[idx_r[2:0]];
      DATA:    field_bit_s = data_byte_s[idx_r[2:0]];
      CRC:     field_bit_s = ~crc_r[4'd15 - idx_r];
      default: field_bit_s = 1'b1;
    endcase
    tx_bit_s = stuff_s ? 1'b0 : field_bit_s;
    line_s   = tx_bit_s ? nrzi_r : ~nrzi_r;
  end

  // Packet sequencer, bit timing, stuffing, CRC and registered line drive.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      idx_r         <= 4'd0;
      ones_r        <= 3'd0;
      crc_r         <= 16'hFFFF;
      pid_r         <= 8'h00;
      shift_r       <= 8'h00;
      bytes_left_r  <= 7'd0;
      is_data_r     <= 1'b0;
      fetch_due_r   <= 1'b0;
      nrzi_r        <= 1'b1;
      dPlus_out     <= 1'b1;
      dMinus_out    <= 1'b0;
      get_tx_packet <= 1'b0;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
      tx_error      <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (state_r == IDLE) begin
        cnt_r         <= '0;
        get_tx_packet <= 1'b0;
        fetch_due_r   <= 1'b0;
        if (req_valid_s && is_data_req_s && (tx_packet_data_size > MAX_SIZE)) begin
          tx_error   <= 1'b1;
          nrzi_r     <= 1'b1;
          dPlus_out  <= 1'b1;
          dMinus_out <= 1'b0;
        end else if (req_valid_s) begin
          // SYNC bit 0 is a 0, so the line leaves J for K on acceptance
          state_r      <= SYNC;
          idx_r        <= 4'd1;
          ones_r       <= 3'd0;
          crc_r        <= 16'hFFFF;
          pid_r        <= pid_of(tx_packet);
          is_data_r    <= is_data_req_s;
          bytes_left_r <= tx_packet_data_size;
          tx_busy      <= 1'b1;
          nrzi_r       <= 1'b0;
          dPlus_out    <= 1'b0;
          dMinus_out   <= 1'b1;
        end else begin
          nrzi_r     <= 1'b1;
          dPlus_out  <= 1'b1;
          dMinus_out <= 1'b0;
        end
      end else begin
        cnt_r         <= wrap_s ? '0 : cnt_r + 1'b1;
        get_tx_packet <= fetch_due_r && (cnt_r == CNT_PRE);
        if (get_tx_packet) begin
          shift_r     <= tx_packet_data;
          fetch_due_r <= 1'b0;
        end
        if (wrap_s) begin
          if (stuff_s) begin
            ones_r     <= 3'd0;
            nrzi_r     <= line_s;
            dPlus_out  <= line_s;
            dMinus_out <= ~line_s;
          end else begin
            case (state_r)
              SYNC, PID, DATA, CRC: begin
                ones_r     <= tx_bit_s ? ones_r + 3'd1 : 3'd0;
                nrzi_r     <= line_s;
                dPlus_out  <= line_s;
                dMinus_out <= ~line_s;
                if (state_r == DATA) begin
                  crc_r <= crc16_step(crc_r, tx_bit_s);
                end
                if (!last_s) begin
                  idx_r <= idx_r + 4'd1;
                end else begin
                  idx_r <= 4'd0;
                  case (state_r)
                    SYNC: state_r <= PID;
                    PID: begin
                      if (!is_data_r) begin
                        state_r <= EOP_SE0;
                      end else if (bytes_left_r == 7'd0) begin
                        state_r <= CRC;
                      end else begin
                        state_r     <= DATA;
                        fetch_due_r <= 1'b1;
                      end
                    end
                    DATA: begin
                      bytes_left_r <= bytes_left_r - 7'd1;
                      if (bytes_left_r == 7'd1) begin
                        state_r <= CRC;
                      end else begin
                        fetch_due_r <= 1'b1;
                      end
                    end
                    default: state_r <= EOP_SE0;
                  endcase
                end
              end
              EOP_SE0: begin
                ones_r     <= 3'd0;
                dPlus_out  <= 1'b0;
                dMinus_out <= 1'b0;
                if (idx_r == 4'd1) begin
                  state_r <= EOP_J;
                  idx_r   <= 4'd0;
                end else begin
                  idx_r <= idx_r + 4'd1;
                end
              end
              EOP_J: begin
                if (idx_r == 4'd0) begin
                  nrzi_r     <= 1'b1;
                  dPlus_out  <= 1'b1;
                  dMinus_out <= 1'b0;
                  idx_r      <= 4'd1;
                end else begin
                  state_r <= IDLE;
                  idx_r   <= 4'd0;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                end
              end
              default: begin
                state_r <= IDLE;
                tx_busy <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_gen.sv
// Directed bench for usb_tx_gen (CLKS_PER_BIT=4): records per-clock line and
// strobe activity after each request and checks hand-computed expectations.
module tb_usb_tx_gen;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet, dPlus_out, dMinus_out, tx_busy, tx_done, tx_error;

  int checks = 0;
  int failures = 0;

  logic [1:0] line_a [0:511];
  logic       pop_a  [0:511];
  logic       done_a [0:511];
  logic       busy_a [0:511];
  logic       err_a  [0:511];
  logic [7:0] dbuf   [0:3];

  always #5 clk = ~clk;

  usb_tx_gen #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet),
    .tx_packet_data_size(tx_packet_data_size), .tx_packet_data(tx_packet_data),
    .get_tx_packet(get_tx_packet), .dPlus_out(dPlus_out), .dMinus_out(dMinus_out),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] code, input logic [6:0] size);
    tx_packet = code;
    tx_packet_data_size = size;
    @(posedge clk); #1;
    tx_packet = 3'd0;
  endtask

  // Cycle 0 is the clock right after the acceptance edge.
  task automatic record(input int n, input int nak_from, input int nak_to,
                        input int rst_from, input int rst_to);
    int npop = 0;
    for (int c = 0; c < n; c++) begin
      line_a[c] = {dPlus_out, dMinus_out};
      pop_a[c]  = get_tx_packet;
      done_a[c] = tx_done;
      busy_a[c] = tx_busy;
      err_a[c]  = tx_error;
      tx_packet_data = (npop < 4) ? dbuf[npop] : 8'h00;
      if (get_tx_packet) npop++;
      tx_packet = (c >= nak_from && c <= nak_to) ? 3'd4 : 3'd0;
      n_rst = (c >= rst_from && c <= rst_to) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // NRZI decode of the first nb bit times; first bit ends up most significant.
  function automatic logic [63:0] decode(input int nb);
    logic [63:0] r = 64'd0;
    logic [1:0]  prev = 2'b10;
    for (int k = 0; k < nb; k++) begin
      r = {r[62:0], line_a[k*CPB] == prev};
      prev = line_a[k*CPB];
    end
    return r;
  endfunction

  function automatic int count_pop(input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(pop_a[c]);
    return s;
  endfunction

  function automatic int count_done(input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(done_a[c]);
    return s;
  endfunction

  function automatic int first_done(input int n);
    for (int c = 0; c < n; c++) if (done_a[c]) return c;
    return -1;
  endfunction

  function automatic logic all_j(input int from, input int n);
    for (int c = from; c < n; c++) if (line_a[c] !== 2'b10) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [63:0] exp_bits;
    logic        flag;
    n_rst = 1'b0; tx_packet = 3'd0; tx_packet_data_size = 7'd0; tx_packet_data = 8'h00;
    dbuf[0] = 8'h00; dbuf[1] = 8'h00; dbuf[2] = 8'h00; dbuf[3] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {dPlus_out, dMinus_out, tx_busy, tx_done, tx_error, get_tx_packet}, 6'b100000);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", {dPlus_out, dMinus_out, tx_busy, tx_done, tx_error, get_tx_packet}, 6'b100000);

    // ACK: SYNC 00000001, PID 0xD2 LSB first 01001011, then EOP
    send(3'd3, 7'd0);
    record(80, -1, -1, -1, -1);
    check("ack_bits", decode(16), 64'h014B);
    flag = 1'b1;
    for (int c = 64; c < 72; c++) if (line_a[c] !== 2'b00) flag = 1'b0;
    for (int c = 72; c < 76; c++) if (line_a[c] !== 2'b10) flag = 1'b0;
    check("ack_eop", flag, 1'b1);
    check("ack_done_at", first_done(80), 76);
    check("ack_done_cnt", count_done(80), 1);
    check("ack_busy_edge", {busy_a[0], busy_a[75], busy_a[76]}, 3'b110);
    check("ack_pops", count_pop(80), 0);

    // DATA0 zero-length: CRC field is ~0xFFFF = 16 zeros
    send(3'd1, 7'd0);
    record(150, -1, -1, -1, -1);
    check("zlp_bits", decode(32), 64'h01C3_0000);
    check("zlp_done_at", first_done(150), 140);
    check("zlp_pops", count_pop(150), 0);
    check("zlp_se0", {line_a[128], line_a[132], line_a[136]}, 6'b00_00_10);

    // DATA1 0xFF: stuff after six 1s in data; CRC ~0xFF00 -> 8 zeros, 8 ones (stuffed)
    dbuf[0] = 8'hFF;
    send(3'd2, 7'd1);
    record(190, -1, -1, -1, -1);
    exp_bits = {22'd0, 8'b00000001, 8'b11010010, 9'b111111011, 8'b00000000, 9'b111111011};
    check("d1_bits", decode(42), exp_bits);
    check("d1_pop_at", {pop_a[62], pop_a[63], pop_a[64]}, 3'b010);
    check("d1_pops", count_pop(190), 1);
    check("d1_done_at", first_done(190), 180);

    // Oversize DATA0 request is rejected
    send(3'd1, 7'd65);
    record(12, -1, -1, -1, -1);
    check("rej_err_pulse", {err_a[0], err_a[1]}, 2'b10);
    check("rej_lines_j", all_j(0, 12), 1'b1);
    flag = 1'b0;
    for (int c = 0; c < 12; c++) flag = flag | busy_a[c] | pop_a[c] | done_a[c];
    check("rej_quiet", flag, 1'b0);

    // Reset asserted during DATA of a 2-byte DATA0 packet
    dbuf[0] = 8'hA5; dbuf[1] = 8'h3C;
    send(3'd1, 7'd2);
    record(200, -1, -1, 70, 72);
    check("rst_busy_before", busy_a[70], 1'b1);
    check("rst_state", {line_a[71], busy_a[71], pop_a[71]}, 4'b1000);
    check("rst_lines_j", all_j(71, 200), 1'b1);
    check("rst_no_done", count_done(200), 0);
    check("rst_pops", count_pop(200), 1);

    // ACK after the aborted packet completes normally
    send(3'd3, 7'd0);
    record(80, -1, -1, -1, -1);
    check("ack2_bits", decode(16), 64'h014B);
    check("ack2_done_at", first_done(80), 76);

    // NAK requested while a 2-byte DATA0 packet is in flight is ignored
    send(3'd1, 7'd2);
    record(400, 2, 150, -1, -1);
    check("nak_pid_bits", decode(16), 64'h01C3);
    check("nak_done_cnt", count_done(400), 1);
    check("nak_pops", count_pop(400), 2);
    check("nak_idle_end", {busy_a[399], line_a[399]}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_gen.md
USB_TX_GEN -- requirements
Module: usb_tx_gen

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clocks per USB bit time (legal range ≥2).
REQ-002 SHALL have parameter MAX_PAYLOAD, default 64, meaning the largest legal data payload in bytes (legal range ≤127).
REQ-003 SHALL have port clk  in  1  the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port n_rst  in  1  reset; synchronous and active-low.
REQ-005 SHALL have port tx_packet  in  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; codes 6 and 7 are treated as none.
REQ-006 SHALL have port tx_packet_data_size  in  7  payload byte count for DATA0 and DATA1; ignored for handshake codes.
REQ-007 SHALL have port tx_packet_data  in  8  head byte of the upstream buffer.
REQ-008 SHALL have port get_tx_packet  out  1  one-clock pop strobe; tx_packet_data is captured on the same edge.
REQ-009 SHALL have ports dPlus_out and dMinus_out  out  1 each  bus line drive.
REQ-010 SHALL have port tx_busy  out  1  high from request acceptance through the end of the EOP J bit.
REQ-011 SHALL have port tx_done  out  1  one-clock completion pulse.
REQ-012 SHALL have port tx_error  out  1  one-clock pulse when a request is rejected.

Function
REQ-013 Bit timing: a counter SHALL run 0..CLKS_PER_BIT-1 while busy; the line state SHALL change only when the counter wraps to 0.
REQ-014 Accept: in IDLE with a nonzero legal code, the request SHALL be latched; the first SYNC bit SHALL drive on the next clock; tx_packet SHALL be ignored while tx_busy is high.
REQ-015 Reject: a DATA request with tx_packet_data_size > MAX_PAYLOAD SHALL pulse tx_error for 1 clock, leave the lines at J, and return to IDLE.
REQ-016 FSM states SHALL be IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J; DATA and CRC SHALL be skipped for handshake codes.
REQ-017 DATA SHALL be skipped when the size is 0 (zero-length packet, ZLP).
REQ-018 SYNC SHALL be 0x80; PIDs SHALL be DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E. All bytes SHALL be sent LSB first.
REQ-019 Data fetch: get_tx_packet SHALL pulse exactly once per payload byte, in the clock in which the previous byte's last bit period ends (first pop at the end of PID). The total number of pops SHALL equal the size.
REQ-020 CRC16: c SHALL initialise to 0xFFFF at SYNC start. For each payload data bit d (stuff bits excluded): fb = d xor c[15]; c = (c shifted left 1) xor (0x8005 if fb).
REQ-021 CRC transmit: ~c SHALL be sent bit 15 first.
REQ-022 Bit stuffing: after six consecutive 1 data bits (counted from the SYNC start, across byte, PID and CRC boundaries) a 0 SHALL be inserted. The stuffed 0 SHALL reset the run count.
REQ-023 The stuff bit SHALL be inserted even when the sixth 1 is the last CRC bit, before EOP.
REQ-024 NRZI: a 0 SHALL toggle the line between J and K; a 1 SHALL hold the line.
REQ-025 Line states: J = (1,0), K = (0,1), SE0 = (0,0). The NRZI state SHALL start from J.
REQ-026 EOP SHALL be SE0 for 2 bit times, then J for 1 bit time.
REQ-027 tx_done SHALL pulse in the clock after the J bit ends; tx_busy SHALL fall on that same edge.
REQ-028 In IDLE, the lines SHALL be J, get_tx_packet SHALL be 0, and tx_done SHALL be 0.

Reset
REQ-029 When n_rst is low at a clock edge, all state SHALL clear: FSM to IDLE, counters to 0, CRC to 0xFFFF, NRZI to J.
REQ-030 During reset, outputs SHALL be dPlus_out=1, dMinus_out=0, and all others 0.
REQ-031 A reset mid-packet SHALL abort immediately, with no EOP, no tx_done and no further pops.

Verification
REQ-032 ACK, CLKS_PER_BIT=4 -> decoded bits 00000001 01001011; SE0 for 8 clocks then J for 4 clocks; tx_done 76 clocks after acceptance; no pops.
REQ-033 DATA0 ZLP -> PID 0xC3, CRC bits all 0, so the line toggles every bit time for 16 bits; zero pops; tx_done after 8+8+16+3 bit times.
REQ-034 DATA1, size 1, byte 0xFF -> one pop. A stuff 0 SHALL follow the 6th 1 of the byte, and the run count SHALL continue correctly into the CRC. The decoded CRC SHALL match a reference model.
REQ-035 DATA0, size 65, default MAX_PAYLOAD -> tx_error pulses 1 clock; lines stay J; no pops; tx_busy stays 0.
REQ-036 n_rst low during the DATA state -> next edge gives lines J, tx_busy 0, no tx_done. A new ACK request afterwards SHALL complete normally.
REQ-037 Request NAK while a DATA0 packet is in progress -> ignored; exactly one tx_done occurs, for the DATA0 packet.
